tinyalu_param: RTL and testbench

Parametrised, multi-latency TinyALU DUT: accepts an operand pair and an `operation_t` opcode on a start strobe and returns a double-width result with a one-cycle `done` pulse. It generalises the fixed 8-bit TinyALU to any operand width and a configurable multiplier pipeline depth. It adds a busy indicator and back-to-back issue of single-cycle operations. It also adds a real `fun_op` (A*A + B), which is compile-time optional. It sits under the existing coverage/tester/scoreboard testbench and uses the `tinyalu_pkg` opcode encoding.

---
 rtl/tinyalu_param_if.sv | 32 +++
 rtl/tinyalu_param.sv | 163 ++++++++++++++++
 tb/tb_tinyalu_param.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : tinyalu_param_if
//  Description : Request/response bundle for tinyalu_param. The requester
//                drives operands, opcode and start; the ALU returns done,
//                busy and the double-width result.
//  Revision    : 1.0  initial release
// ============================================================================
interface tinyalu_param_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               done;
    logic               busy;
    logic [2*WIDTH-1:0] result;

    // Requester side
    modport master (
        output A, B, op, start,
        input  done, busy, result
    );

    // ALU side
    modport slave (
        input  A, B, op, start,
        output done, busy, result
    );
endinterface
`default_nettype wire

// File: rtl/tinyalu_param.sv
`default_nettype none
// ============================================================================
//  Module      : tinyalu_param
//  Description : Parametrised multi-latency TinyALU. Single-cycle add/and/xor
//                complete on the acceptance edge and may issue back-to-back;
//                mul completes MUL_LAT edges later; the optional fun op
//                (A*A + B) takes one more edge. Build option macro:
//                TINYALU_FUN_OP_EN enables fun_op and its FUN_ADD state.
//  Revision    : 1.0  initial release
// ============================================================================
module tinyalu_param #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  wire              clk,
    input  wire              reset_n,
    tinyalu_param_if.slave   bus
);
    // Opcode encoding shared with the verification package
    localparam logic [2:0] c_op_no  = 3'b000;
    localparam logic [2:0] c_op_add = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_xor = 3'b011;
    localparam logic [2:0] c_op_mul = 3'b100;
`ifdef TINYALU_FUN_OP_EN
    localparam logic [2:0] c_op_fun = 3'b101;
`endif
    localparam logic [2:0] c_op_rst = 3'b111;

    // Counter only needs to hold MUL_LAT-1; keep at least one bit
    localparam int                 c_cnt_w    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL     = 2'd1
`ifdef TINYALU_FUN_OP_EN
        ,S_FUN_ADD = 2'd2
`endif
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
`ifdef TINYALU_FUN_OP_EN
    logic               r_fun;
    logic [2*WIDTH-1:0] r_prod;
`endif

    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;

    // Single-cycle results come straight from the live operands at acceptance;
    // the product is formed from the operands captured at acceptance.
    assign w_sum  = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Control FSM with registered done/busy/result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
`ifdef TINYALU_FUN_OP_EN
            r_fun      <= 1'b0;
            r_prod     <= '0;
`endif
            bus.done   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            c_op_add: begin
                                bus.result <= {{(WIDTH-1){1'b0}}, w_sum};
                                bus.done   <= 1'b1;
                            end
                            c_op_and: begin
                                bus.result <= {{WIDTH{1'b0}}, bus.A & bus.B};
                                bus.done   <= 1'b1;
                            end
                            c_op_xor: begin
                                bus.result <= {{WIDTH{1'b0}}, bus.A ^ bus.B};
                                bus.done   <= 1'b1;
                            end
                            c_op_mul: begin
                                r_a      <= bus.A;
                                r_b      <= bus.B;
`ifdef TINYALU_FUN_OP_EN
                                r_fun    <= 1'b0;
`endif
                                r_cnt    <= c_cnt_init;
                                bus.busy <= 1'b1;
                                r_state  <= S_MUL;
                            end
`ifdef TINYALU_FUN_OP_EN
                            c_op_fun: begin
                                // A*A shares the multiplier, B is kept for the final add
                                r_a      <= bus.A;
                                r_b      <= bus.A;
                                r_prod   <= {{WIDTH{1'b0}}, bus.B};
                                r_fun    <= 1'b1;
                                r_cnt    <= c_cnt_init;
                                bus.busy <= 1'b1;
                                r_state  <= S_MUL;
                            end
`endif
                            c_op_rst: begin
                                bus.result <= '0;
                            end
                            c_op_no: begin
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
`ifdef TINYALU_FUN_OP_EN
                        if (r_fun) begin
                            // r_prod holds the addend; swap in the square
                            r_prod  <= w_prod;
                            r_b     <= r_prod[WIDTH-1:0];
                            r_state <= S_FUN_ADD;
                        end else begin
                            bus.result <= w_prod;
                            bus.done   <= 1'b1;
                            bus.busy   <= 1'b0;
                            r_state    <= S_IDLE;
                        end
`else
                        bus.result <= w_prod;
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        r_state    <= S_IDLE;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef TINYALU_FUN_OP_EN
                S_FUN_ADD: begin
                    bus.result <= r_prod + {{WIDTH{1'b0}}, r_b};
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                    r_state    <= S_IDLE;
                end
`endif
                default: begin
                    bus.busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tinyalu_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tinyalu_param
//  Description : Directed self-checking bench for tinyalu_param (WIDTH=8,
//                MUL_LAT=3). Honours TINYALU_FUN_OP_EN for fun_op results.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tinyalu_param;
    localparam logic [2:0] NO  = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] XOR = 3'b011;
    localparam logic [2:0] MUL = 3'b100;
    localparam logic [2:0] FUN = 3'b101;
    localparam logic [2:0] UNU = 3'b110;
    localparam logic [2:0] RST = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        done;
    } vec_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    tinyalu_param_if #(.WIDTH(8)) bus ();

    tinyalu_param #(.WIDTH(8), .MUL_LAT(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
    endtask

    // Issue one op, then watch 12 cycles: latency (E0-relative edge of done,
    // -1 if none), done pulse count, busy cycle count and final result.
    task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int exp_lat, input int exp_busy,
                          input logic [15:0] exp_res);
        int lat;
        int ndone;
        int nbusy;
        lat = -1; ndone = 0; nbusy = 0;
        @(negedge clk);
        drive(op, a, b);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (bus.done) begin
                if (lat < 0) lat = k - 1;
                ndone++;
            end
            if (bus.busy) nbusy++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_ndone"}, ndone, (exp_lat < 0) ? 0 : 1);
        chk({name, "_busy"}, nbusy, exp_busy);
        chk({name, "_res"}, {16'h0, bus.result}, {16'h0, exp_res});
    endtask

    initial begin
        vec_t vecs[11];
        int   seen;

        total = 0;
        bad   = 0;
        vecs[0]  = '{ADD, 8'hFF, 8'h01, 16'h0100, 1'b1};
        vecs[1]  = '{XOR, 8'hA5, 8'h0F, 16'h00AA, 1'b1};
        vecs[2]  = '{AND, 8'hA5, 8'h0F, 16'h0005, 1'b1};
        vecs[3]  = '{ADD, 8'h80, 8'h80, 16'h0100, 1'b1};
        vecs[4]  = '{RST, 8'h12, 8'h34, 16'h0000, 1'b0};
        vecs[5]  = '{ADD, 8'h02, 8'h03, 16'h0005, 1'b1};
        vecs[6]  = '{NO,  8'h12, 8'h34, 16'h0005, 1'b0};
        vecs[7]  = '{UNU, 8'h12, 8'h34, 16'h0005, 1'b0};
        vecs[8]  = '{AND, 8'hFF, 8'hFF, 16'h00FF, 1'b1};
        vecs[9]  = '{XOR, 8'hFF, 8'hFF, 16'h0000, 1'b1};
        vecs[10] = '{ADD, 8'h7F, 8'h01, 16'h0080, 1'b1};

        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = NO;
        bus.A     = '0;
        bus.B     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_result", {16'h0, bus.result}, 32'h0);
        reset_n = 1'b1;

        // Single-cycle ops issued on consecutive edges
        @(negedge clk);
        drive(vecs[0].op, vecs[0].a, vecs[0].b);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_done", i), {31'h0, bus.done}, {31'h0, vecs[i].done});
            chk($sformatf("vec%0d_res", i), {16'h0, bus.result}, {16'h0, vecs[i].res});
            chk($sformatf("vec%0d_busy", i), {31'h0, bus.busy}, 32'h0);
            if (i + 1 < 11) drive(vecs[i+1].op, vecs[i+1].a, vecs[i+1].b);
            else bus.start = 1'b0;
        end

        // mul FF*FF with an add attempted while busy
        @(negedge clk);
        drive(MUL, 8'hFF, 8'hFF);
        @(negedge clk);
        chk("mul_busy1", {31'h0, bus.busy}, 32'h1);
        chk("mul_done1", {31'h0, bus.done}, 32'h0);
        drive(ADD, 8'h01, 8'h01);
        @(negedge clk);
        chk("mul_busy2", {31'h0, bus.busy}, 32'h1);
        chk("mul_done2", {31'h0, bus.done}, 32'h0);
        @(negedge clk);
        chk("mul_busy3", {31'h0, bus.busy}, 32'h1);
        chk("mul_done3", {31'h0, bus.done}, 32'h0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("mul_done", {31'h0, bus.done}, 32'h1);
        chk("mul_busy_off", {31'h0, bus.busy}, 32'h0);
        chk("mul_res", {16'h0, bus.result}, 32'h0000FE01);
        @(negedge clk);
        chk("mul_done_once", {31'h0, bus.done}, 32'h0);
        chk("mul_add_ignored", {16'h0, bus.result}, 32'h0000FE01);

`ifdef TINYALU_FUN_OP_EN
        run_op("fun", FUN, 8'h10, 8'h05, 4, 4, 16'h0105);
`else
        run_op("fun_off", FUN, 8'h10, 8'h05, -1, 0, 16'hFE01);
`endif
        run_op("mul2", MUL, 8'h0C, 8'h0D, 3, 3, 16'h009C);

        // xor, and back-to-back, then mul in the second done cycle
        @(negedge clk);
        drive(XOR, 8'hA5, 8'h0F);
        @(negedge clk);
        chk("b2b_xor_done", {31'h0, bus.done}, 32'h1);
        chk("b2b_xor_res", {16'h0, bus.result}, 32'h000000AA);
        drive(AND, 8'hA5, 8'h0F);
        @(negedge clk);
        chk("b2b_and_done", {31'h0, bus.done}, 32'h1);
        chk("b2b_and_res", {16'h0, bus.result}, 32'h00000005);
        drive(MUL, 8'h09, 8'h11);
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_mul_busy", {31'h0, bus.busy}, 32'h1);
        chk("b2b_mul_done0", {31'h0, bus.done}, 32'h0);
        repeat (2) @(negedge clk);
        chk("b2b_mul_early", {31'h0, bus.done}, 32'h0);
        @(negedge clk);
        chk("b2b_mul_done", {31'h0, bus.done}, 32'h1);
        chk("b2b_mul_res", {16'h0, bus.result}, 32'h00000099);

        // Asynchronous reset in the middle of a mul
        @(negedge clk);
        drive(MUL, 8'hFF, 8'hFF);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", {31'h0, bus.busy}, 32'h0);
        chk("arst_done", {31'h0, bus.done}, 32'h0);
        chk("arst_result", {16'h0, bus.result}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        chk("arst_no_done", seen, 0);
        run_op("post_rst_add", ADD, 8'h02, 8'h03, 0, 0, 16'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
